// File: rtl/mhsa_sched.sv
// Top-level MHSA sequencer: runs NUM_PROJ linear passes and then one attention pass,
// using four-phase handshakes. Adds a per-state watchdog, abort and a saturating run-cycle counter.
module mhsa_sched #(
    parameter int          NUM_PROJ   = 3,
    parameter logic [31:0] W_BASE     = 32'h0,
    parameter logic [31:0] W_STRIDE   = 32'd128,
    parameter logic [31:0] RES_BASE   = 32'h0,
    parameter logic [31:0] RES_STRIDE = 32'd128,
    parameter int          TIMEOUT    = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [31:0] cycle_count,
    output logic [1:0]  proj_idx,
    output logic        lin_start,
    input  logic        lin_done,
    output logic [31:0] lin_w_base,
    output logic [31:0] lin_res_base,
    output logic        attn_start,
    input  logic        attn_done
);

    typedef enum logic [2:0] {
        S_IDLE, S_LIN_REQ, S_LIN_DRAIN, S_ATTN_REQ, S_ATTN_DRAIN, S_DONE, S_ERR
    } state_t;

    localparam logic [1:0]  LAST_PROJ = 2'(NUM_PROJ - 1);
    localparam logic [31:0] WD_LAST   = 32'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [1:0]  proj_q, proj_d;
    logic        err_q, err_d;
    logic [31:0] cc_q, cc_d;
    logic [31:0] wd_q, wd_d;
    logic [31:0] w_base_q, w_base_d;
    logic [31:0] res_base_q, res_base_d;
    logic        waiting;

    always_comb begin
        state_d    = state_q;
        proj_d     = proj_q;
        err_d      = err_q;
        cc_d       = cc_q;
        wd_d       = '0;
        w_base_d   = w_base_q;
        res_base_d = res_base_q;

        waiting = (state_q == S_LIN_REQ)  || (state_q == S_LIN_DRAIN) ||
                  (state_q == S_ATTN_REQ) || (state_q == S_ATTN_DRAIN);

        if (waiting && cc_q != 32'hFFFF_FFFF)
            cc_d = cc_q + 32'd1;

        case (state_q)
            S_IDLE, S_ERR: begin
                if (start && !abort) begin
                    state_d = S_LIN_REQ;
                    proj_d  = 2'd0;
                    err_d   = 1'b0;
                    cc_d    = '0;
                end
            end
            S_LIN_REQ:    if (lin_done) state_d = S_LIN_DRAIN;
            S_LIN_DRAIN: begin
                if (!lin_done) begin
                    if (proj_q < LAST_PROJ) begin
                        proj_d  = proj_q + 2'd1;
                        state_d = S_LIN_REQ;
                    end else begin
                        state_d = S_ATTN_REQ;
                    end
                end
            end
            S_ATTN_REQ:   if (attn_done) state_d = S_ATTN_DRAIN;
            S_ATTN_DRAIN: if (!attn_done) state_d = S_DONE;
            S_DONE:       state_d = S_IDLE;
            default:      state_d = S_IDLE;
        endcase

        // Watchdog overrides any acknowledge; abort overrides both.
        if (waiting && wd_q == WD_LAST) begin
            state_d = S_ERR;
            proj_d  = proj_q;
            err_d   = 1'b1;
        end
        if (abort && state_q != S_IDLE && state_q != S_ERR) begin
            state_d = S_IDLE;
            proj_d  = proj_q;
        end

        if (waiting && state_d == state_q)
            wd_d = wd_q + 32'd1;

        // Load the pass addresses on entry to LIN_REQ so they are valid with lin_start.
        if (state_d == S_LIN_REQ) begin
            w_base_d   = W_BASE + {30'b0, proj_d} * W_STRIDE;
            res_base_d = RES_BASE + {30'b0, proj_d} * RES_STRIDE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            proj_q     <= '0;
            err_q      <= 1'b0;
            cc_q       <= '0;
            wd_q       <= '0;
            w_base_q   <= '0;
            res_base_q <= '0;
        end else begin
            state_q    <= state_d;
            proj_q     <= proj_d;
            err_q      <= err_d;
            cc_q       <= cc_d;
            wd_q       <= wd_d;
            w_base_q   <= w_base_d;
            res_base_q <= res_base_d;
        end
    end

    assign busy         = waiting;
    assign done         = (state_q == S_DONE);
    assign error        = err_q;
    assign cycle_count  = cc_q;
    assign proj_idx     = proj_q;
    assign lin_start    = (state_q == S_LIN_REQ);
    assign attn_start   = (state_q == S_ATTN_REQ);
    assign lin_w_base   = w_base_q;
    assign lin_res_base = res_base_q;

endmodule

// File: tb/tb_mhsa_sched.sv
// Directed bench for mhsa_sched: a nominal-address instance and a wrapping-address instance
// share every input; the bench plays both engines with a four-phase handshake.
module tb_mhsa_sched;

    logic        clk = 1'b0;
    logic        rst, start, abort, lin_done, attn_done;
    logic        busy, done, error, lin_start, attn_start;
    logic [31:0] cycle_count, lin_w_base, lin_res_base;
    logic [1:0]  proj_idx;

    logic        w_busy, w_done, w_error, w_lin_start, w_attn_start;
    logic [31:0] w_cycle_count, w_lin_w_base, w_lin_res_base;
    logic [1:0]  w_proj_idx;

    int vecs = 0, errs = 0;
    int busy_cnt = 0, done_cnt = 0, attn_rises = 0;
    logic attn_prev = 1'b0;

    always #5 clk = ~clk;

    mhsa_sched #(.TIMEOUT(16)) u_dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .busy(busy), .done(done), .error(error), .cycle_count(cycle_count),
        .proj_idx(proj_idx), .lin_start(lin_start), .lin_done(lin_done),
        .lin_w_base(lin_w_base), .lin_res_base(lin_res_base),
        .attn_start(attn_start), .attn_done(attn_done)
    );

    mhsa_sched #(.TIMEOUT(16), .W_BASE(32'hFFFF_FFC0), .W_STRIDE(32'd64)) u_wrap (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .busy(w_busy), .done(w_done), .error(w_error), .cycle_count(w_cycle_count),
        .proj_idx(w_proj_idx), .lin_start(w_lin_start), .lin_done(lin_done),
        .lin_w_base(w_lin_w_base), .lin_res_base(w_lin_res_base),
        .attn_start(w_attn_start), .attn_done(attn_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (busy) busy_cnt++;
        if (done) done_cnt++;
        if (attn_start && !attn_prev) attn_rises++;
        attn_prev = attn_start;
    endtask

    task automatic clr_counts();
        busy_cnt = 0; done_cnt = 0; attn_rises = 0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_lin();
        for (int i = 0; i < 40 && lin_start !== 1'b1; i++) tick();
        chk("lin_start_seen", {31'b0, lin_start}, 32'd1);
    endtask

    // One linear pass: ack after lat cycles, drop ack drop+stuck cycles after the request falls.
    task automatic lin_pass(input int idx, input int lat, input int drop, input int stuck, input bit poke);
        logic [31:0] exp_wrap;
        wait_lin();
        exp_wrap = 32'hFFFF_FFC0 + 32'(idx) * 32'd64;
        chk("proj_idx", {30'b0, proj_idx}, 32'(idx));
        chk("lin_w_base", lin_w_base, 32'(idx) * 32'd128);
        chk("lin_res_base", lin_res_base, 32'(idx) * 32'd128);
        chk("wrap_w_base", w_lin_w_base, exp_wrap);
        if (poke) begin
            pulse_start();
            chk("start_while_busy", {30'b0, proj_idx}, 32'(idx));
            repeat (lat - 1) tick();
        end else begin
            repeat (lat) tick();
        end
        chk("lin_req_held", {31'b0, lin_start}, 32'd1);
        lin_done = 1'b1;
        tick();
        chk("lin_req_drop", {31'b0, lin_start}, 32'd0);
        repeat (drop + stuck) tick();
        chk("lin_drain_hold", {31'b0, lin_start}, 32'd0);
        lin_done = 1'b0;
        tick();
        if (idx < 2) chk("next_lin_start", {31'b0, lin_start}, 32'd1);
        else         chk("attn_start_rise", {31'b0, attn_start}, 32'd1);
    endtask

    task automatic attn_pass(input int lat, input int drop);
        for (int i = 0; i < 40 && attn_start !== 1'b1; i++) tick();
        chk("attn_start_seen", {31'b0, attn_start}, 32'd1);
        repeat (lat) tick();
        attn_done = 1'b1;
        tick();
        chk("attn_req_drop", {31'b0, attn_start}, 32'd0);
        repeat (drop) tick();
        attn_done = 1'b0;
        tick();
        chk("done_pulse", {31'b0, done}, 32'd1);
        chk("busy_in_done", {31'b0, busy}, 32'd0);
        tick();
        chk("done_cleared", {31'b0, done}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; lin_done = 1'b0; attn_done = 1'b0;
        repeat (3) tick();
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_error", {31'b0, error}, 32'd0);
        chk("rst_cycle_count", cycle_count, 32'd0);
        chk("rst_w_base", lin_w_base, 32'd0);
        chk("rst_res_base", lin_res_base, 32'd0);
        chk("rst_lin_start", {31'b0, lin_start}, 32'd0);
        chk("rst_attn_start", {31'b0, attn_start}, 32'd0);
        chk("rst_proj_idx", {30'b0, proj_idx}, 32'd0);
        rst = 1'b0;
        tick();

        // Nominal run: 10-cycle ack, drop 2 cycles after request falls; 4 handshakes x 14 cycles.
        clr_counts();
        pulse_start();
        chk("accept_busy", {31'b0, busy}, 32'd1);
        lin_pass(0, 10, 2, 0, 1'b0);
        lin_pass(1, 10, 2, 0, 1'b1);
        lin_pass(2, 10, 2, 0, 1'b0);
        attn_pass(10, 2);
        chk("nom_cycle_count", cycle_count, 32'd56);
        chk("nom_cc_vs_busy", cycle_count, 32'(busy_cnt));
        chk("nom_done_count", 32'(done_cnt), 32'd1);
        chk("nom_attn_rises", 32'(attn_rises), 32'd1);
        chk("nom_w_base_hold", lin_w_base, 32'd256);
        repeat (3) tick();
        chk("nom_cc_frozen", cycle_count, 32'd56);

        // Stuck ack on pass 0, then abort during pass 1.
        clr_counts();
        pulse_start();
        lin_pass(0, 3, 2, 3, 1'b0);
        wait_lin();
        chk("abort_proj_idx", {30'b0, proj_idx}, 32'd1);
        repeat (2) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_lin_start", {31'b0, lin_start}, 32'd0);
        chk("abort_attn_start", {31'b0, attn_start}, 32'd0);
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_error", {31'b0, error}, 32'd0);
        tick();
        chk("abort_no_done", 32'(done_cnt), 32'd0);

        clr_counts();
        pulse_start();
        lin_pass(0, 2, 1, 0, 1'b0);
        lin_pass(1, 2, 1, 0, 1'b0);
        lin_pass(2, 2, 1, 0, 1'b0);
        attn_pass(2, 1);
        chk("rerun_cc_vs_busy", cycle_count, 32'(busy_cnt));

        // start and abort together in IDLE: nothing starts.
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        chk("coll_busy", {31'b0, busy}, 32'd0);
        chk("coll_lin_start", {31'b0, lin_start}, 32'd0);

        // Watchdog: attention never acknowledges; ERR 16 cycles after ATTN_REQ entry.
        pulse_start();
        lin_pass(0, 2, 1, 0, 1'b0);
        lin_pass(1, 2, 1, 0, 1'b0);
        lin_pass(2, 2, 1, 0, 1'b0);
        repeat (15) tick();
        chk("wd_not_yet", {31'b0, error}, 32'd0);
        chk("wd_attn_held", {31'b0, attn_start}, 32'd1);
        tick();
        chk("wd_error", {31'b0, error}, 32'd1);
        chk("wd_attn_start", {31'b0, attn_start}, 32'd0);
        chk("wd_busy", {31'b0, busy}, 32'd0);
        tick();
        chk("wd_sticky", {31'b0, error}, 32'd1);
        pulse_start();
        chk("wd_restart_error", {31'b0, error}, 32'd0);
        chk("wd_restart_proj", {30'b0, proj_idx}, 32'd0);
        chk("wd_restart_lin", {31'b0, lin_start}, 32'd1);

        // Reset mid-run during pass 1.
        lin_pass(0, 2, 1, 0, 1'b0);
        wait_lin();
        chk("pre_rst_w_base", lin_w_base, 32'd128);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_lin_start", {31'b0, lin_start}, 32'd0);
        chk("mid_rst_busy", {31'b0, busy}, 32'd0);
        chk("mid_rst_proj", {30'b0, proj_idx}, 32'd0);
        chk("mid_rst_w_base", lin_w_base, 32'd0);
        chk("mid_rst_res_base", lin_res_base, 32'd0);
        chk("mid_rst_cc", cycle_count, 32'd0);
        chk("mid_rst_wrap_base", w_lin_w_base, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
